imm_gen_pipe: RTL and testbench

Pipelined, parametrised immediate generator for the decode stage. It accepts one instruction word per cycle under a valid/ready handshake and extracts and sign-extends its immediate to XLEN bits. The result leaves through a registered output stage backed by a skid buffer, so both in_ready and all outputs are driven from flops. It adds a CSR zero-extended immediate type, a per-beat invalid flag, a saturating invalid-instruction counter and a pass-through tag.

---
 rtl/imm_gen_pipe.sv | 208 ++++++++++++++++++++
 tb/tb_imm_gen_pipe.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : imm_gen_pipe
//  Description : Pipelined RISC-V immediate generator. One instruction per
//                cycle in, extended immediate out, through a registered
//                output stage backed by a one-entry skid buffer. Adds a CSR
//                zero-extended type, per-beat invalid flag, saturating
//                invalid counter and a pass-through tag.
//                Optional macro IMM_GEN_OPCODE_DECODE_EN: derive the
//                immediate type from opcode/funct3 instead of in_imm_type.
//  Revision    : 1.0  initial release
// ============================================================================
module imm_gen_pipe #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [2:0]       in_imm_type,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic             out_invalid,
    output logic [TAG_W-1:0] out_tag,
    output logic [CNT_W-1:0] err_cnt
);

    // Immediate type encodings
    localparam logic [2:0] IMM_I   = 3'b000;
    localparam logic [2:0] IMM_S   = 3'b001;
    localparam logic [2:0] IMM_B   = 3'b010;
    localparam logic [2:0] IMM_U   = 3'b011;
    localparam logic [2:0] IMM_J   = 3'b100;
    localparam logic [2:0] IMM_Z   = 3'b101;
    localparam logic [2:0] IMM_BAD = 3'b110;

    // Occupancy states: bit0 = OUT entry valid, bit1 = SKID entry valid
    localparam logic [1:0] S_EMPTY = 2'b00;
    localparam logic [1:0] S_ONE   = 2'b01;
    localparam logic [1:0] S_FULL  = 2'b11;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic             r_in_ready;
    logic             w_in_ready_nxt;

    logic [2:0]       w_type;
    logic [31:0]      w_raw32;
    logic             w_inv;
    logic [XLEN-1:0]  w_imm;

    logic             w_acc;
    logic             w_out_free;
    logic             w_load_out_new;
    logic             w_load_out_skid;
    logic             w_load_skid;
    logic             w_cnt_inc;

    logic [XLEN-1:0]  r_out_imm;
    logic             r_out_inv;
    logic [TAG_W-1:0] r_out_tag;
    logic [XLEN-1:0]  r_skid_imm;
    logic             r_skid_inv;
    logic [TAG_W-1:0] r_skid_tag;
    logic [CNT_W-1:0] r_err_cnt;

`ifdef IMM_GEN_OPCODE_DECODE_EN
    // The type input is superseded by opcode decode in this build
    logic w_unused_type;
    assign w_unused_type = ^in_imm_type;

    // Derive the immediate type from opcode and funct3[2]
    always_comb begin
        w_type = IMM_BAD;
        case (in_instr[6:0])
            7'b0010011, 7'b0000011,
            7'b1100111, 7'b0011011: w_type = IMM_I;
            7'b1110011:             w_type = in_instr[14] ? IMM_Z : IMM_I;
            7'b0100011:             w_type = IMM_S;
            7'b1100011:             w_type = IMM_B;
            7'b0110111, 7'b0010111: w_type = IMM_U;
            7'b1101111:             w_type = IMM_J;
            default:                w_type = IMM_BAD;
        endcase
    end
`else
    // The opcode field carries no immediate bits, so it is unused here
    logic w_unused_opc;
    assign w_unused_opc = ^in_instr[6:0];
    assign w_type       = in_imm_type;
`endif

    // Assemble the immediate, already sign-extended to 32 bits
    always_comb begin
        w_raw32 = 32'd0;
        w_inv   = 1'b0;
        case (w_type)
            IMM_I: w_raw32 = {{20{in_instr[31]}}, in_instr[31:20]};
            IMM_S: w_raw32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            IMM_B: w_raw32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                              in_instr[30:25], in_instr[11:8], 1'b0};
            IMM_U: w_raw32 = {in_instr[31:12], 12'd0};
            IMM_J: w_raw32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                              in_instr[20], in_instr[30:21], 1'b0};
            IMM_Z: w_raw32 = {27'd0, in_instr[19:15]};
            default: begin
                w_raw32 = 32'd0;
                w_inv   = 1'b1;
            end
        endcase
    end

    // Z has bit 31 clear, so a plain sign extension also covers it
    assign w_imm = XLEN'($signed(w_raw32));

    // Handshake: in_ready is low only while SKID holds a beat
    assign w_acc      = in_valid && r_in_ready;
    assign w_out_free = !r_state[0] || out_ready;

    // Occupancy register; reset forces EMPTY and ready high
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= w_in_ready_nxt;
        end
    end

    // Next occupancy from accept/drain; flush empties both entries
    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: w_state_nxt = w_acc ? S_ONE : S_EMPTY;
                S_ONE: begin
                    if (out_ready) w_state_nxt = w_acc ? S_ONE  : S_EMPTY;
                    else           w_state_nxt = w_acc ? S_FULL : S_ONE;
                end
                S_FULL:  w_state_nxt = out_ready ? S_ONE : S_FULL;
                default: w_state_nxt = S_EMPTY;
            endcase
        end
    end

    // Datapath load enables and next in_ready derived from the transition
    always_comb begin
        w_in_ready_nxt  = (w_state_nxt != S_FULL);
        w_load_out_skid = !flush && (r_state == S_FULL) && out_ready;
        w_load_out_new  = !flush && w_acc && w_out_free;
        w_load_skid     = !flush && w_acc && !w_out_free;
        w_cnt_inc       = !flush && w_acc && w_inv && !(&r_err_cnt);
    end

    // Output and skid payload registers; SKID is always older than a new beat
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_imm  <= '0;
            r_out_inv  <= 1'b0;
            r_out_tag  <= '0;
            r_skid_imm <= '0;
            r_skid_inv <= 1'b0;
            r_skid_tag <= '0;
        end else begin
            if (w_load_out_skid) begin
                r_out_imm <= r_skid_imm;
                r_out_inv <= r_skid_inv;
                r_out_tag <= r_skid_tag;
            end else if (w_load_out_new) begin
                r_out_imm <= w_imm;
                r_out_inv <= w_inv;
                r_out_tag <= in_tag;
            end
            if (w_load_skid) begin
                r_skid_imm <= w_imm;
                r_skid_inv <= w_inv;
                r_skid_tag <= in_tag;
            end
        end
    end

    // Saturating count of accepted invalid beats; flush leaves it intact
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if (w_cnt_inc) begin
            r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_state[0];
    assign out_imm     = r_out_imm;
    assign out_invalid = r_out_inv;
    assign out_tag     = r_out_tag;
    assign err_cnt     = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imm_gen_pipe
//  Description : Self-checking bench for imm_gen_pipe. Drives a 64-bit/16-bit
//                counter instance and a 32-bit/2-bit counter instance from the
//                same stimulus and compares both against a queue-based model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, out_ready;
    logic [31:0] in_instr;
    logic [2:0]  in_imm_type;
    logic [7:0]  in_tag;

    logic        in_ready, out_valid, out_invalid;
    logic [63:0] out_imm;
    logic [7:0]  out_tag;
    logic [15:0] err_cnt;

    logic        in_ready32, out_valid32, out_invalid32;
    logic [31:0] out_imm32;
    logic [7:0]  out_tag32;
    logic [1:0]  err_cnt32;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(64), .TAG_W(8), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_imm_type(in_imm_type), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_imm(out_imm), .out_invalid(out_invalid), .out_tag(out_tag),
        .err_cnt(err_cnt)
    );

    imm_gen_pipe #(.XLEN(32), .TAG_W(8), .CNT_W(2)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready32),
        .in_instr(in_instr), .in_imm_type(in_imm_type), .in_tag(in_tag),
        .out_valid(out_valid32), .out_ready(out_ready),
        .out_imm(out_imm32), .out_invalid(out_invalid32), .out_tag(out_tag32),
        .err_cnt(err_cnt32)
    );

    typedef struct packed {
        logic [63:0] imm;
        logic        inv;
        logic [7:0]  tag;
    } beat_t;

    beat_t q[$];
    int    m_cnt;
    int    m_cnt32;
    int    n_chk = 0;
    int    n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Effective type as seen by the design in this build
    function automatic logic [2:0] ref_type(input logic [31:0] ins, input logic [2:0] ty);
`ifdef IMM_GEN_OPCODE_DECODE_EN
        logic [6:0] op;
        op = ins[6:0];
        if (op == 7'h13 || op == 7'h03 || op == 7'h67 || op == 7'h1B) return 3'd0;
        if (op == 7'h73) return ins[14] ? 3'd5 : 3'd0;
        if (op == 7'h23) return 3'd1;
        if (op == 7'h63) return 3'd2;
        if (op == 7'h37 || op == 7'h17) return 3'd3;
        if (op == 7'h6F) return 3'd4;
        return 3'd6;
`else
        if (ins == 32'hDEADBEEF) return ty; // keeps ins referenced
        return ty;
`endif
    endfunction

    // Reference immediate computed with signed 64-bit arithmetic
    function automatic logic [63:0] ref_imm(input logic [31:0] ins, input logic [2:0] ty);
        longint s;
        longint r;
        s = longint'($signed(ins));
        case (ty)
            3'd0: r = s >>> 20;
            3'd1: r = ((s >>> 25) <<< 5) | longint'(ins[11:7]);
            3'd2: r = ((s >>> 31) <<< 12) | (longint'(ins[7]) << 11)
                    | (longint'(ins[30:25]) << 5) | (longint'(ins[11:8]) << 1);
            3'd3: r = (s >>> 12) <<< 12;
            3'd4: r = ((s >>> 31) <<< 20) | (longint'(ins[19:12]) << 12)
                    | (longint'(ins[20]) << 11) | (longint'(ins[30:21]) << 1);
            3'd5: r = longint'(ins[19:15]);
            default: r = 0;
        endcase
        return r;
    endfunction

    task automatic compare_all();
        beat_t       b;
        logic [31:0] e32;
        chk("out_valid",   {63'd0, out_valid},   {63'd0, q.size() > 0});
        chk("in_ready",    {63'd0, in_ready},    {63'd0, q.size() < 2});
        chk("err_cnt",     64'(err_cnt),         64'(m_cnt));
        chk("out_valid32", {63'd0, out_valid32}, {63'd0, q.size() > 0});
        chk("in_ready32",  {63'd0, in_ready32},  {63'd0, q.size() < 2});
        chk("err_cnt32",   64'(err_cnt32),       64'(m_cnt32));
        if (q.size() > 0) begin
            b   = q[0];
            e32 = b.imm[31:0];
            chk("out_imm",       out_imm,                  b.imm);
            chk("out_invalid",   {63'd0, out_invalid},     {63'd0, b.inv});
            chk("out_tag",       64'(out_tag),             64'(b.tag));
            chk("out_imm32",     64'(out_imm32),           64'(e32));
            chk("out_invalid32", {63'd0, out_invalid32},   {63'd0, b.inv});
            chk("out_tag32",     64'(out_tag32),           64'(b.tag));
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, then compare
    task automatic step(input logic v, input logic [31:0] ins, input logic [2:0] ty,
                        input logic [7:0] tg, input logic ordy, input logic fl,
                        input logic rn);
        logic  rdy;
        beat_t b;
        logic [2:0] et;
        in_valid = v; in_instr = ins; in_imm_type = ty; in_tag = tg;
        out_ready = ordy; flush = fl; rst_n = rn;
        @(posedge clk);
        if (!rn) begin
            q.delete(); m_cnt = 0; m_cnt32 = 0;
        end else if (fl) begin
            q.delete();
        end else begin
            rdy = (q.size() < 2);
            if (q.size() > 0 && ordy) void'(q.pop_front());
            if (v && rdy) begin
                et    = ref_type(ins, ty);
                b.imm = ref_imm(ins, et);
                b.inv = (et > 3'd5);
                b.tag = tg;
                q.push_back(b);
                if (b.inv) begin
                    if (m_cnt < 65535) m_cnt++;
                    if (m_cnt32 < 3) m_cnt32++;
                end
            end
        end
        #1;
        compare_all();
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 32'd0, 3'd0, 8'd0, ordy, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        step(1'b0, 32'd0, 3'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        chk("rst_out_valid", {63'd0, out_valid},   64'd0);
        chk("rst_out_imm",   out_imm,              64'd0);
        chk("rst_out_inv",   {63'd0, out_invalid}, 64'd0);
        chk("rst_out_tag",   64'(out_tag),         64'd0);
        chk("rst_err_cnt",   64'(err_cnt),         64'd0);
        chk("rst_in_ready",  {63'd0, in_ready},    64'd1);
    endtask

    initial begin
        m_cnt = 0; m_cnt32 = 0;
        do_reset();

        // First beat: I-type all-ones immediate
        step(1'b1, 32'hFFF00093, 3'd0, 8'h5A, 1'b1, 1'b0, 1'b1);
`ifndef IMM_GEN_OPCODE_DECODE_EN
        chk("plan_i_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("plan_i_tag", 64'(out_tag), 64'h5A);
        chk("plan_i_inv", {63'd0, out_invalid}, 64'd0);

        // Back-to-back B, J, U
        step(1'b1, 32'h8000_0063, 3'd2, 8'h01, 1'b1, 1'b0, 1'b1);
        chk("plan_b_imm", out_imm, 64'hFFFF_FFFF_FFFF_F000);
        step(1'b1, 32'h0010_006F, 3'd4, 8'h02, 1'b1, 1'b0, 1'b1);
        chk("plan_j_imm", out_imm, 64'h800);
        step(1'b1, 32'h8000_0037, 3'd3, 8'h03, 1'b1, 1'b0, 1'b1);
        chk("plan_u_imm32", 64'(out_imm32), 64'h8000_0000);

        // Z type
        step(1'b1, 32'h000F_8000, 3'd5, 8'h04, 1'b1, 1'b0, 1'b1);
        chk("plan_z_imm", out_imm, 64'h1F);
`else
        // csrrsi decodes as Z regardless of in_imm_type
        step(1'b1, 32'h000F_E073, 3'd6, 8'h04, 1'b1, 1'b0, 1'b1);
        chk("plan_csrrsi_imm", out_imm, 64'h1F);
`endif
        idle(1'b1);

        // Backpressure: three offers with out_ready low, two accepted
        step(1'b1, 32'h0010_0093, 3'd0, 8'h10, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h0020_0093, 3'd0, 8'h11, 1'b0, 1'b0, 1'b1);
        chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
        step(1'b1, 32'h0030_0093, 3'd0, 8'h12, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h0030_0093, 3'd0, 8'h12, 1'b1, 1'b0, 1'b1);
        chk("bp_drain_ready", {63'd0, in_ready}, 64'd1);
        step(1'b1, 32'h0030_0093, 3'd0, 8'h12, 1'b1, 1'b0, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Invalid type saturation on the 2-bit counter instance
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, $urandom, 3'd6, 8'(i), 1'b1, 1'b0, 1'b1);
`ifndef IMM_GEN_OPCODE_DECODE_EN
            chk("inv_imm", out_imm, 64'd0);
            chk("inv_flag", {63'd0, out_invalid}, 64'd1);
            chk("inv_cnt32", 64'(err_cnt32), 64'((i < 3) ? i + 1 : 3));
`endif
        end
        idle(1'b1);

        // Flush from FULL with a new invalid beat offered
        step(1'b1, 32'h0000_0013, 3'd0, 8'h20, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h0000_0013, 3'd0, 8'h21, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'hFFFF_FFFF, 3'd7, 8'h22, 1'b0, 1'b1, 1'b1);
        chk("flush_valid", {63'd0, out_valid}, 64'd0);
        chk("flush_ready", {63'd0, in_ready},  64'd1);

        // Reset from FULL
        step(1'b1, 32'h0000_0013, 3'd0, 8'h30, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h0000_0013, 3'd0, 8'h31, 1'b0, 1'b0, 1'b1);
        do_reset();

        // Randomized traffic with occasional flush and reset
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) != 0, $urandom, 3'($urandom_range(0, 7)),
                 8'($urandom), $urandom_range(0, 2) != 0,
                 $urandom_range(0, 49) == 0, $urandom_range(0, 299) != 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
